// File: rtl/ltz_key_event_if.sv
// Level input and event outputs of the key event generator, grouped for port hookup.
// "release" is a reserved word, so the release event is carried on release_pulse.
interface ltz_key_event_if #(
    parameter int CNT_W = 8
);
    logic             lvl;
    logic             press;
    logic             release_pulse;
    logic             long;
    logic             rpt;
    logic             held;
    logic [CNT_W-1:0] rpt_cnt;

    modport master (output lvl, input press, release_pulse, long, rpt, held, rpt_cnt);
    modport slave  (input lvl, output press, release_pulse, long, rpt, held, rpt_cnt);
endinterface

// File: rtl/ltz_key_event.sv
// Turns a filtered, clk-synchronous key level into 1-cycle press/release/long/repeat
// pulses, plus a held flag and a saturating count of repeats in the current press.
module ltz_key_event #(
    parameter logic ACTIVE_LVL   = 1'b1,
    parameter int   TICK_DIV     = 1000,
    parameter int   LONG_TICKS   = 500,
    parameter int   REPEAT_TICKS = 100,
    parameter int   CNT_W        = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ltz_key_event_if.slave bus
);
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic              RPT_EN    = (REPEAT_TICKS != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              rpt_q, rpt_d;
    logic              held_q, held_d;
    logic              asserted;
    logic              tick;

    assign asserted = (bus.lvl == ACTIVE_LVL);
    assign tick     = (state_q != IDLE) && (pre_cnt_q == PRE_LAST);

    // Deassertion is tested first in every active state, so release always wins over long/rpt.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        pre_cnt_d  = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        rpt_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (asserted) begin
                    state_d    = PRESS;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    pre_cnt_d  = '0;
                    rpt_cnt_d  = '0;
                end
            end
            PRESS: begin
                if (!asserted) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (tick && hold_cnt_q == LONG_LAST) begin
                    state_d    = HOLD;
                    long_d     = 1'b1;
                    hold_cnt_d = '0;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!asserted) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (RPT_EN && tick && hold_cnt_q == RPT_LAST) begin
                    rpt_d      = 1'b1;
                    hold_cnt_d = '0;
                    if (rpt_cnt_q != CNT_MAX) begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end else if (RPT_EN && tick) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            rpt_q      <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            rpt_q      <= rpt_d;
            held_q     <= held_d;
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long          = long_q;
    assign bus.rpt           = rpt_q;
    assign bus.held          = held_q;
    assign bus.rpt_cnt       = rpt_cnt_q;
endmodule

// File: tb/tb_ltz_key_event.sv
// Scoreboard bench for ltz_key_event: each driven press pushes its expected pulse schedule,
// and pulses seen on four differently parameterised instances are matched against it.
`timescale 1ns/1ps
module tb_ltz_key_event;
    localparam int NDUT = 4;
    localparam int TDIV [NDUT] = '{4, 4, 4, 4};
    localparam int LTCK [NDUT] = '{3, 3, 3, 3};
    localparam int RTCK [NDUT] = '{2, 0, 2, 2};
    localparam int CWID [NDUT] = '{8, 8, 2, 8};
    localparam bit ACT  [NDUT] = '{1'b1, 1'b1, 1'b1, 1'b0};

    localparam int K_PRESS = 1;
    localparam int K_REL   = 2;
    localparam int K_LONG  = 3;
    localparam int K_RPT   = 4;
    localparam int K_MULTI = 9;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int held;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        lvl_v     [NDUT];
    logic        press_v   [NDUT];
    logic        release_v [NDUT];
    logic        long_v    [NDUT];
    logic        rpt_v     [NDUT];
    logic        held_v    [NDUT];
    logic [31:0] cnt_v     [NDUT];

    ev_t exp_q [NDUT][$];
    int  cyc = 0;
    int  tests_run = 0;
    int  tests_failed = 0;

    ltz_key_event_if #(.CNT_W(8)) if0 ();
    ltz_key_event_if #(.CNT_W(8)) if1 ();
    ltz_key_event_if #(.CNT_W(2)) if2 ();
    ltz_key_event_if #(.CNT_W(8)) if3 ();

    ltz_key_event #(.ACTIVE_LVL(1'b1), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .CNT_W(8))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    ltz_key_event #(.ACTIVE_LVL(1'b1), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(0), .CNT_W(8))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    ltz_key_event #(.ACTIVE_LVL(1'b1), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .CNT_W(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    ltz_key_event #(.ACTIVE_LVL(1'b0), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .CNT_W(8))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.lvl      = lvl_v[0];
    assign if1.lvl      = lvl_v[1];
    assign if2.lvl      = lvl_v[2];
    assign if3.lvl      = lvl_v[3];
    assign press_v[0]   = if0.press;
    assign press_v[1]   = if1.press;
    assign press_v[2]   = if2.press;
    assign press_v[3]   = if3.press;
    assign release_v[0] = if0.release_pulse;
    assign release_v[1] = if1.release_pulse;
    assign release_v[2] = if2.release_pulse;
    assign release_v[3] = if3.release_pulse;
    assign long_v[0]    = if0.long;
    assign long_v[1]    = if1.long;
    assign long_v[2]    = if2.long;
    assign long_v[3]    = if3.long;
    assign rpt_v[0]     = if0.rpt;
    assign rpt_v[1]     = if1.rpt;
    assign rpt_v[2]     = if2.rpt;
    assign rpt_v[3]     = if3.rpt;
    assign held_v[0]    = if0.held;
    assign held_v[1]    = if1.held;
    assign held_v[2]    = if2.held;
    assign held_v[3]    = if3.held;
    assign cnt_v[0]     = 32'(if0.rpt_cnt);
    assign cnt_v[1]     = 32'(if1.rpt_cnt);
    assign cnt_v[2]     = 32'(if2.rpt_cnt);
    assign cnt_v[3]     = 32'(if3.rpt_cnt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals the index of the most recent rising edge when read at a falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic void pushEv(input int d, input int k, input int c, input int n, input int h);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cnt  = n;
        e.held = h;
        exp_q[d].push_back(e);
    endfunction

    // Expected schedule of a press whose level is sampled asserted on edges e0 .. e0+dur-1.
    function automatic void pushPress(input int d, input int e0, input int dur, input bit with_rel);
        int per_long;
        int per_rpt;
        int cmax;
        int c;
        int n;
        int cnt;
        per_long = LTCK[d] * TDIV[d];
        per_rpt  = RTCK[d] * TDIV[d];
        cmax     = (1 << CWID[d]) - 1;
        n        = 0;
        cnt      = 0;
        pushEv(d, K_PRESS, e0, 0, 1);
        c = e0 + per_long;
        if (c < e0 + dur) begin
            pushEv(d, K_LONG, c, 0, 1);
            if (per_rpt > 0) begin
                c = c + per_rpt;
                while (c < e0 + dur) begin
                    n++;
                    cnt = (n > cmax) ? cmax : n;
                    pushEv(d, K_RPT, c, cnt, 1);
                    c = c + per_rpt;
                end
            end
        end
        if (with_rel) pushEv(d, K_REL, e0 + dur, cnt, 0);
    endfunction

    task automatic applyStimulus(input int d, input int dur, input int gap);
        int e0;
        @(negedge clk);
        lvl_v[d] = ACT[d];
        e0 = cyc + 1;
        pushPress(d, e0, dur, 1'b1);
        repeat (dur) @(negedge clk);
        lvl_v[d] = ~ACT[d];
        repeat (gap) @(negedge clk);
    endtask

    // Match every observed pulse to the scoreboard and flag expectations whose cycle passed.
    always @(negedge clk) begin
        int  npulse;
        int  kind;
        ev_t e;
        for (int d = 0; d < NDUT; d++) begin
            while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
                checkOutput($sformatf("missed_d%0d_kind%0d", d, exp_q[d][0].kind), cyc, exp_q[d][0].cyc);
                void'(exp_q[d].pop_front());
            end
            npulse = int'(press_v[d]) + int'(release_v[d]) + int'(long_v[d]) + int'(rpt_v[d]);
            if (npulse > 0) begin
                if (npulse > 1)        kind = K_MULTI;
                else if (press_v[d])   kind = K_PRESS;
                else if (release_v[d]) kind = K_REL;
                else if (long_v[d])    kind = K_LONG;
                else                   kind = K_RPT;
                if (exp_q[d].size() == 0) begin
                    checkOutput($sformatf("unexpected_d%0d_cyc%0d", d, cyc), kind, 0);
                end else begin
                    e = exp_q[d].pop_front();
                    checkOutput($sformatf("kind_d%0d_cyc%0d", d, e.cyc), kind, e.kind);
                    checkOutput($sformatf("time_d%0d_kind%0d", d, e.kind), cyc, e.cyc);
                    checkOutput($sformatf("rpt_cnt_d%0d_cyc%0d", d, e.cyc), int'(cnt_v[d]), e.cnt);
                    checkOutput($sformatf("held_d%0d_cyc%0d", d, e.cyc), int'(held_v[d]), e.held);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) lvl_v[d] = ~ACT[d];
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("reset_pulses_d%0d", d),
                        int'({press_v[d], release_v[d], long_v[d], rpt_v[d], held_v[d]}), 0);
            checkOutput($sformatf("reset_rpt_cnt_d%0d", d), int'(cnt_v[d]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] long hold with repeats");
        applyStimulus(0, 40, 5);
        checkOutput("t1_rpt_cnt_kept", int'(cnt_v[0]), 3);
        checkOutput("t1_held_after", int'(held_v[0]), 0);

        $display("[TB] short press");
        applyStimulus(0, 8, 4);
        checkOutput("t2_rpt_cnt", int'(cnt_v[0]), 0);

        $display("[TB] release on the long tick edge, then one cycle later");
        applyStimulus(0, 12, 4);
        applyStimulus(0, 13, 4);

        $display("[TB] repeat disabled");
        applyStimulus(1, 100, 4);
        checkOutput("t4_no_rpt_cnt", int'(cnt_v[1]), 0);

        $display("[TB] rpt_cnt saturation");
        applyStimulus(2, 60, 4);
        checkOutput("t4_sat_cnt", int'(cnt_v[2]), 3);

        $display("[TB] active-low level and reset mid-hold");
        applyStimulus(3, 6, 4);
        @(negedge clk);
        lvl_v[3] = ACT[3];
        e0 = cyc + 1;
        pushPress(3, e0, 15, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("t5_held_in_hold", int'(held_v[3]), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_reset_pulses",
                    int'({press_v[3], release_v[3], long_v[3], rpt_v[3], held_v[3]}), 0);
        checkOutput("t5_reset_rpt_cnt", int'(cnt_v[3]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        pushPress(3, e0, 5, 1'b1);
        repeat (5) @(negedge clk);
        lvl_v[3] = ~ACT[3];

        repeat (6) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("drain_d%0d", d), exp_q[d].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
